// File: rtl/alula.sv
// Two-stage 4-bit ALU: registered operands feed a ripple-carry adder whose
// sum and carry-out are registered again, giving a fixed two-edge latency.
module alula (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       s0,
   input  logic       s1,
   input  logic       cin,
   output logic [3:0] d,
   output logic       cout
);

   localparam int unsigned W = 4;

   logic [W-1:0] a_d, a_q;
   logic [W-1:0] b_d, b_q;
   logic [1:0]   sel_d, sel_q;
   logic         cin_d, cin_q;
   logic [W-1:0] d_d, d_q;
   logic         cout_d, cout_q;

   logic [W-1:0] y;
   logic [W-1:0] g;
   logic [W-1:0] p;
   logic         carry;

   // Input stage capture
   always_comb begin
      a_d   = a;
      b_d   = b;
      sel_d = {s0, s1};
      cin_d = cin;
   end

   // Operand mux and generate/propagate ripple adder
   always_comb begin
      y      = b_q;
      g      = '0;
      p      = '0;
      carry  = cin_q;
      d_d    = '0;
      cout_d = 1'b0;
      case (sel_q)
         2'b00:   y = b_q;
         2'b01:   y = ~b_q;
         2'b10:   y = '0;
         default: y = '1;
      endcase
      g = a_q & y;
      p = a_q ^ y;
      for (int i = 0; i < int'(W); i++) begin
         d_d[i] = p[i] ^ carry;
         carry  = g[i] | (p[i] & carry);
      end
      cout_d = carry;
   end

   // Both stages clear together so an in-flight result is dropped on reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q    <= '0;
         b_q    <= '0;
         sel_q  <= '0;
         cin_q  <= 1'b0;
         d_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sel_q  <= sel_d;
         cin_q  <= cin_d;
         d_q    <= d_d;
         cout_q <= cout_d;
      end
   end

   assign d    = d_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_alula.sv
// Self-checking bench for alula: directed table checks plus random vectors
// against an arithmetic reference delayed by two clock edges.
module tb_alula;

   logic       CLK;
   logic       RST;
   logic [3:0] a;
   logic [3:0] b;
   logic       s0;
   logic       s1;
   logic       cin;
   logic [3:0] d;
   logic       cout;

   int checks;
   int failures;

   logic [4:0] exp_out;
   logic [4:0] exp_mid;

   alula dut (
      .CLK  (CLK),
      .RST  (RST),
      .a    (a),
      .b    (b),
      .s0   (s0),
      .s1   (s1),
      .cin  (cin),
      .d    (d),
      .cout (cout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Operation table in plain integer arithmetic: op = {s0,s1,cin}
   function automatic logic [4:0] ref_alu(input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [2:0] op);
      int av;
      int bv;
      int r;
      av = int'(ra);
      bv = int'(rb);
      case (op)
         3'd0:    r = av + bv;
         3'd1:    r = av + bv + 1;
         3'd2:    r = av + (15 - bv);
         3'd3:    r = av + (15 - bv) + 1;
         3'd4:    r = av;
         3'd5:    r = av + 1;
         3'd6:    r = av + 15;
         default: r = av + 16;
      endcase
      return 5'(r);
   endfunction

   // Called at a negedge: drive, take one rising edge, advance the model, return at the next negedge
   task automatic cycle(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [2:0] op, input logic trst);
      a   = ta;
      b   = tb_v;
      s0  = op[2];
      s1  = op[1];
      cin = op[0];
      RST = trst;
      @(posedge CLK);
      if (trst) begin
         exp_out = 5'd0;
         exp_mid = 5'd0;
      end else begin
         exp_out = exp_mid;
         exp_mid = ref_alu(ta, tb_v, op);
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(4'($urandom), 4'($urandom), 3'($urandom), 1'b1);
         checks++;
         if ({cout, d} !== 5'b0_0000) begin
            failures++;
            $display("FAIL reset_hold[%0d] got=%b expected=%b", i, {cout, d}, 5'b0_0000);
         end
      end
      for (int i = 0; i < 2; i++) begin
         cycle(4'd0, 4'd0, 3'd0, 1'b0);
         checks++;
         if ({cout, d} !== 5'b0_0000) begin
            failures++;
            $display("FAIL reset_release[%0d] got=%b expected=%b", i, {cout, d}, 5'b0_0000);
         end
      end
   endtask

   task automatic test_op_sweep();
      logic [4:0] tbl [8];
      tbl[0] = 5'b0_1111; tbl[1] = 5'b1_0000; tbl[2] = 5'b1_0100; tbl[3] = 5'b1_0101;
      tbl[4] = 5'b0_1010; tbl[5] = 5'b0_1011; tbl[6] = 5'b1_1001; tbl[7] = 5'b1_1010;
      for (int k = 0; k < 9; k++) begin
         cycle(4'b1010, 4'b0101, 3'(k % 8), 1'b0);
         if (k >= 1) begin
            checks++;
            if ({cout, d} !== tbl[k-1]) begin
               failures++;
               $display("FAIL op_sweep[%0d] got=%b expected=%b", k - 1, {cout, d}, tbl[k-1]);
            end
         end
      end
   endtask

   task automatic test_carry_borrow();
      logic [3:0] va  [4];
      logic [3:0] vb  [4];
      logic [2:0] vop [4];
      logic [4:0] ve  [4];
      va[0] = 4'b1111; vb[0] = 4'b0000; vop[0] = 3'b001; ve[0] = 5'b1_0000;
      va[1] = 4'b0111; vb[1] = 4'b0001; vop[1] = 3'b000; ve[1] = 5'b0_1000;
      va[2] = 4'b0010; vb[2] = 4'b0101; vop[2] = 3'b011; ve[2] = 5'b0_1101;
      va[3] = 4'b0101; vb[3] = 4'b0101; vop[3] = 3'b011; ve[3] = 5'b1_0000;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) cycle(va[k], vb[k], vop[k], 1'b0);
         else       cycle(4'd0, 4'd0, 3'd0, 1'b0);
         if (k >= 1) begin
            checks++;
            if ({cout, d} !== ve[k-1]) begin
               failures++;
               $display("FAIL carry_borrow[%0d] got=%b expected=%b", k - 1, {cout, d}, ve[k-1]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] want [16];
      for (int k = 0; k < 17; k++) begin
         logic [3:0] ra;
         logic [3:0] rb;
         logic [2:0] op;
         ra = 4'(k);
         rb = 4'(15 - k);
         op = 3'(k % 8);
         if (k < 16) want[k] = ref_alu(ra, rb, op);
         cycle(ra, rb, op, 1'b0);
         if (k >= 1) begin
            checks++;
            if ({cout, d} !== want[k-1]) begin
               failures++;
               $display("FAIL back_to_back[%0d] got=%b expected=%b", k - 1, {cout, d}, want[k-1]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] first;
      for (int k = 0; k < 3; k++) cycle(4'b1111, 4'b1111, 3'b001, 1'b0);
      cycle(4'b1110, 4'b0011, 3'b001, 1'b1);
      checks++;
      if ({cout, d} !== 5'b0_0000) begin
         failures++;
         $display("FAIL mid_reset_edge got=%b expected=%b", {cout, d}, 5'b0_0000);
      end
      cycle(4'b1001, 4'b0110, 3'b001, 1'b0);
      checks++;
      if ({cout, d} !== 5'b0_0000) begin
         failures++;
         $display("FAIL mid_reset_discard got=%b expected=%b", {cout, d}, 5'b0_0000);
      end
      first = ref_alu(4'b1001, 4'b0110, 3'b001);
      cycle(4'b0011, 4'b0001, 3'b000, 1'b0);
      checks++;
      if ({cout, d} !== first) begin
         failures++;
         $display("FAIL mid_reset_first_valid got=%b expected=%b", {cout, d}, first);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int k = 0; k < 1200; k++) begin
         cycle(4'($urandom), 4'($urandom), 3'($urandom), 1'b0);
         checks++;
         if ({cout, d} !== exp_out) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d] got=%b expected=%b", k, {cout, d}, exp_out);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_out  = 5'd0;
      exp_mid  = 5'd0;
      RST = 1'b1;
      a   = 4'd0;
      b   = 4'd0;
      s0  = 1'b0;
      s1  = 1'b0;
      cin = 1'b0;
      @(negedge CLK);
      test_reset();
      test_op_sweep();
      test_carry_borrow();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alula.md
ALULA -- requirements
Module: alula

Interface
REQ-001 The module SHALL have exactly one clock and one reset: the reset SHALL be synchronous and active-high.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 RST  input  1  synchronous active-high reset; sampled on the rising edge of CLK.
REQ-004 a  input  4  operand A, unsigned.
REQ-005 b  input  4  operand B, unsigned.
REQ-006 s0  input  1  operation select, upper bit.
REQ-007 s1  input  1  operation select, lower bit.
REQ-008 cin  input  1  carry-in to the adder.
REQ-009 d  output  4  registered 4-bit result.
REQ-010 cout  output  1  registered carry-out of the adder.
REQ-011 The module SHALL have no parameters; all widths are fixed.

Function
REQ-012 Input stage: on each rising edge with RST low, the module SHALL register a, b, s0, s1 and cin.
REQ-013 Operand mux: from registered values, Y SHALL be B for {s0,s1}=00, ~B for 01, 4'b0000 for 10 and 4'b1111 for 11.
REQ-014 Adder: the module SHALL compute the 5-bit result {C4,S} = A + Y + CIN (all unsigned), with no overflow flag and no saturation.
REQ-015 Carry structure: per bit Gi = Ai&Yi and Pi = Ai^Yi; C(i+1) = Gi | Pi&Ci, with C0 = CIN; Si = Pi^Ci; C4 drives cout.
REQ-016 Operation table for {s0,s1,cin}:
- 000: A+B
- 001: A+B+1
- 010: A+~B (A-B-1)
- 011: A-B
- 100: A
- 101: A+1
- 110: A-1
- 111: A
REQ-017 Output stage: on each rising edge with RST low, the module SHALL register {cout,d} from {C4,S}.
REQ-018 Latency: inputs sampled at edge N SHALL appear on d/cout immediately after edge N+1, which is 2 register stages.
REQ-019 Throughput: the module SHALL accept new inputs every cycle; there is no handshake and no stall.
REQ-020 Wrap-around: results SHALL wrap modulo 16 in d, with the carry reported in cout. For example, 1111+0001 gives d=0000 and cout=1.
REQ-021 Subtraction borrow convention: for operations 010 and 011, cout=1 SHALL indicate no borrow, i.e. A >= B for 011.
REQ-022 Inputs are not required to stay stable between edges; only values present at the rising edge matter.

Reset
REQ-023 When RST is high at a rising edge, both the input and the output stage registers SHALL clear to 0; d=0000 and cout=0 after that edge.
REQ-024 RST SHALL take priority over input capture at the same edge.
REQ-025 Registered operands of 0 with select 00 and cin 0 SHALL produce 0, so outputs stay 0 for one further edge after reset release.
REQ-026 Reset mid-operation: an in-flight result SHALL be discarded.
REQ-027 After RST deasserts, the first valid output SHALL be for inputs sampled at the first edge with RST low, and SHALL appear after the next edge.
REQ-028 Before the first reset, d and cout SHALL NOT be defined.

Verification
REQ-029 Hold RST high for 2 edges with arbitrary inputs -> d=0000, cout=0; after release with a=0, b=0, sel=000, outputs remain 0.
REQ-030 a=1010, b=0101, sweep {s0,s1,cin} from 000 to 111, one new value per cycle; each result appears 2 edges after it is applied. Required {cout,d}:
- 000: 0,1111
- 001: 1,0000
- 010: 1,0100
- 011: 1,0101
- 100: 0,1010
- 101: 0,1011
- 110: 1,1001
- 111: 1,1010
REQ-031 Carry chain: a=1111, b=0000, sel=001 -> d=0000, cout=1; a=0111, b=0001, sel=000 -> d=1000, cout=0.
REQ-032 Borrow: a=0010, b=0101, sel=011 -> d=1101, cout=0; a=0101, b=0101, sel=011 -> d=0000, cout=1.
REQ-033 Pipeline and reset: apply back-to-back distinct inputs on consecutive edges -> each result appears in order, one per cycle. Assert RST for one edge mid-stream -> outputs become 0 and the in-flight result is never produced.
REQ-034 Random self-check: compare {cout,d} against a reference model of A+Y+cin delayed by 2 cycles for at least 1000 random vectors -> zero mismatches.
